serial_code_lock: RTL and testbench



---
 rtl/serial_code_lock_pkg.sv | 17 +
 rtl/serial_code_lock_lockout_timer.sv | 28 ++
 rtl/serial_code_lock.sv | 157 +++++++++++++++
 tb/tb_serial_code_lock.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_code_lock_pkg.sv
// Shared types and width helpers for the serial code lock.
package serial_code_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Width needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_safe(input int value);
    if (value <= 2) return 1;
    return $clog2(value);
  endfunction

endpackage

// File: rtl/serial_code_lock_lockout_timer.sv
// Loadable down-counter that times the lockout window; done while at zero.
module serial_code_lock_lockout_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] value;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (count && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/serial_code_lock.sv
// Serial code lock: takes an N-bit code MSB first over a valid/ready
// handshake, reports pass/fail over a second handshake, counts consecutive
// failures and locks out for LOCKOUT_CYCLES after MAX_FAIL of them.
// Optional code programming is enabled by defining SERIAL_CODE_LOCK_PROG_EN.
module serial_code_lock
  import serial_code_lock_pkg::*;
#(
  parameter int             N              = 4,
  parameter logic [N-1:0]   DEFAULT_CODE   = N'(4'b1011),
  parameter int             MAX_FAIL       = 3,
  parameter int             LOCKOUT_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ser_val,
  input  logic                                ser_data,
  output logic                                ser_ready,
  output logic                                output_val,
  output logic                                output_data,
  input  logic                                output_ready,
  output logic                                locked_out,
  output logic [clog2_safe(MAX_FAIL+1)-1:0]   fail_count
`ifdef SERIAL_CODE_LOCK_PROG_EN
  ,
  input  logic                                prog_req,
  input  logic [N-1:0]                        prog_code
`endif
);

  localparam int CNT_W  = clog2_safe(N);
  localparam int FAIL_W = clog2_safe(MAX_FAIL + 1);
  localparam int TMR_W  = clog2_safe(LOCKOUT_CYCLES);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(N - 1);
  localparam logic [FAIL_W-1:0] FAIL_SAT = FAIL_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_idx;
  logic             mismatch;
  logic [N-1:0]     code_reg;
  logic             ser_xfer;
  logic             out_xfer;
  logic             bit_err;
  logic             last_fail;
  logic             lock_load;
  logic             lock_count;
  logic             tmr_done;

  // Moore outputs: everything decodes from state and registered flags.
  assign ser_ready   = (state == IDLE) || (state == COLLECT);
  assign output_val  = (state == RESULT);
  assign output_data = (state == RESULT) && !mismatch;
  assign locked_out  = (state == LOCKOUT);

  assign ser_xfer  = ser_val && ser_ready;
  assign out_xfer  = output_val && output_ready;

  // Bit k of the stream is compared against code_reg[N-1-k]; in IDLE the
  // counter is zero so the same index selects the MSB.
  assign bit_idx   = LAST_BIT - bit_cnt;
  assign bit_err   = ser_data ^ code_reg[bit_idx];

  assign last_fail  = (int'(fail_count) + 1) >= MAX_FAIL;
  assign lock_load  = (state == RESULT) && output_ready && mismatch && last_fail;
  assign lock_count = (state == LOCKOUT);

`ifdef SERIAL_CODE_LOCK_PROG_EN
  logic armed;

  // Code register is reprogrammable only right after a pass, until the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg <= DEFAULT_CODE;
      armed    <= 1'b0;
    end else if ((state == IDLE) && armed && prog_req) begin
      code_reg <= prog_code;
      armed    <= 1'b0;
    end else if (ser_xfer) begin
      armed    <= 1'b0;
    end else if (out_xfer && !mismatch) begin
      armed    <= 1'b1;
    end
  end
`else
  assign code_reg = DEFAULT_CODE;
`endif

  // Control FSM: collect all N bits (no early abort), report, then count
  // failures and enter lockout when the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      mismatch   <= 1'b0;
      fail_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ser_xfer) begin
            mismatch <= bit_err;
            bit_cnt  <= CNT_W'(1);
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (ser_xfer) begin
            mismatch <= mismatch | bit_err;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= RESULT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RESULT: begin
          if (output_ready) begin
            mismatch <= 1'b0;
            bit_cnt  <= '0;
            if (!mismatch) begin
              fail_count <= '0;
              state      <= IDLE;
            end else if (!last_fail) begin
              fail_count <= fail_count + 1'b1;
              state      <= IDLE;
            end else begin
              fail_count <= FAIL_SAT;
              state      <= LOCKOUT;
            end
          end
        end
        LOCKOUT: begin
          if (tmr_done) begin
            fail_count <= '0;
            bit_cnt    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  serial_code_lock_lockout_timer #(
    .W (TMR_W)
  ) u_lockout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lock_load),
    .load_val (TMR_LOAD),
    .count    (lock_count),
    .done     (tmr_done)
  );

endmodule

// File: tb/tb_serial_code_lock.sv
// Self-checking bench for serial_code_lock (N=4, code 1011, MAX_FAIL=3,
// LOCKOUT_CYCLES=8). Define SERIAL_CODE_LOCK_PROG_EN to also cover programming.
module tb_serial_code_lock;

  localparam int N        = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_val;
  logic       ser_data;
  logic       ser_ready;
  logic       output_val;
  logic       output_data;
  logic       output_ready;
  logic       locked_out;
  logic [1:0] fail_count;
`ifdef SERIAL_CODE_LOCK_PROG_EN
  logic         prog_req;
  logic [N-1:0] prog_code;
`endif

  serial_code_lock #(
    .N              (N),
    .DEFAULT_CODE   (4'b1011),
    .MAX_FAIL       (MAX_FAIL),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_val      (ser_val),
    .ser_data     (ser_data),
    .ser_ready    (ser_ready),
    .output_val   (output_val),
    .output_data  (output_data),
    .output_ready (output_ready),
    .locked_out   (locked_out),
    .fail_count   (fail_count)
`ifdef SERIAL_CODE_LOCK_PROG_EN
    ,
    .prog_req     (prog_req),
    .prog_code    (prog_code)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  logic exp_q[$];

  typedef struct {
    logic [3:0] code;
    int         gap;
    logic       pass;
    int         fc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: pop the expected result on every output handshake.
  always @(negedge clk) begin
    if (!rst && output_val && output_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic e;
        e = exp_q.pop_front();
        check("result", int'(output_data), int'(e));
      end
    end
  end

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    @(negedge clk);
    while (!ser_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ser_ready_timeout", 0, 1);
    ser_val  = 1'b1;
    ser_data = b;
    @(posedge clk);
    #1 ser_val = 1'b0;
  endtask

  task automatic send_code(input logic [3:0] code, input int gap, input logic exp);
    for (int i = 3; i >= 0; i--) begin
      if (i != 3) repeat (gap) @(posedge clk);
      send_bit(code[i]);
    end
    exp_q.push_back(exp);
  endtask

  // Full code with output_ready high: result the cycle after the last bit,
  // handshake on the next edge, then the post-result state is checked.
  task automatic run_code(input logic [3:0] code, input int gap, input logic exp_pass,
                          input int exp_fc, input logic exp_lock, input string tag);
    send_code(code, gap, exp_pass);
    @(negedge clk);
    check({tag, "_latency_val"}, int'(output_val), 1);
    check({tag, "_result_ready"}, int'(ser_ready), 0);
    @(negedge clk);
    check({tag, "_after_ready"}, int'(ser_ready), int'(!exp_lock));
    check({tag, "_after_lock"}, int'(locked_out), int'(exp_lock));
    check({tag, "_after_fc"}, int'(fail_count), exp_fc);
    check({tag, "_after_val"}, int'(output_val), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   cnt;
    logic bad;

    vecs[0] = '{code: 4'b1011, gap: 0, pass: 1'b1, fc: 0};
    vecs[1] = '{code: 4'b0111, gap: 0, pass: 1'b0, fc: 1};
    vecs[2] = '{code: 4'b1011, gap: 2, pass: 1'b1, fc: 0};
    vecs[3] = '{code: 4'b1010, gap: 0, pass: 1'b0, fc: 1};
    vecs[4] = '{code: 4'b1111, gap: 1, pass: 1'b0, fc: 2};
    vecs[5] = '{code: 4'b1011, gap: 0, pass: 1'b1, fc: 0};
    vecs[6] = '{code: 4'b0011, gap: 3, pass: 1'b0, fc: 1};
    vecs[7] = '{code: 4'b1011, gap: 1, pass: 1'b1, fc: 0};

    rst          = 1'b1;
    ser_val      = 1'b0;
    ser_data     = 1'b0;
    output_ready = 1'b1;
`ifdef SERIAL_CODE_LOCK_PROG_EN
    prog_req     = 1'b0;
    prog_code    = '0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ser_ready", int'(ser_ready), 1);
    check("rst_output_val", int'(output_val), 0);
    check("rst_output_data", int'(output_data), 0);
    check("rst_locked_out", int'(locked_out), 0);
    check("rst_fail_count", int'(fail_count), 0);
    rst = 1'b0;

    // Table of codes, output always ready
    for (int i = 0; i < 8; i++) begin
      run_code(vecs[i].code, vecs[i].gap, vecs[i].pass, vecs[i].fc, 1'b0,
               $sformatf("vec%0d", i));
    end

    // Backpressure: result held stable for 5 cycles
    output_ready = 1'b0;
    send_code(4'b1011, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_val", int'(output_val), 1);
      check("bp_data", int'(output_data), 1);
      check("bp_ser_ready", int'(ser_ready), 0);
    end
    @(posedge clk);
    #1 output_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_after_ready", int'(ser_ready), 1);
    check("bp_after_val", int'(output_val), 0);
    check("bp_after_fc", int'(fail_count), 0);

    // Lockout after three failures, exactly LOCK_CYC cycles long
    run_code(4'b0000, 0, 1'b0, 1, 1'b0, "lk1");
    run_code(4'b1100, 0, 1'b0, 2, 1'b0, "lk2");
    run_code(4'b0111, 0, 1'b0, 3, 1'b1, "lk3");
    cnt = 0;
    bad = 1'b0;
    while (locked_out && cnt < 40) begin
      cnt++;
      if (ser_ready || output_val || (fail_count != 2'd3)) bad = 1'b1;
      @(negedge clk);
    end
    check("lock_length", cnt, LOCK_CYC);
    check("lock_outputs_quiet", int'(bad), 0);
    check("lock_exit_fc", int'(fail_count), 0);
    check("lock_exit_ready", int'(ser_ready), 1);
    run_code(4'b1011, 0, 1'b1, 0, 1'b0, "post_lock");

    // Reset after two bits of a code
    run_code(4'b0000, 0, 1'b0, 1, 1'b0, "pre_rst");
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_seq_ready", int'(ser_ready), 1);
    check("rst_seq_fc", int'(fail_count), 0);
    check("rst_seq_lock", int'(locked_out), 0);
    @(negedge clk);
    rst = 1'b0;
    run_code(4'b1011, 0, 1'b1, 0, 1'b0, "rst_seq_pass");

    // Reset during lockout
    run_code(4'b0001, 0, 1'b0, 1, 1'b0, "rl1");
    run_code(4'b0010, 1, 1'b0, 2, 1'b0, "rl2");
    run_code(4'b1001, 0, 1'b0, 3, 1'b1, "rl3");
    repeat (3) @(negedge clk);
    check("rst_lock_before", int'(locked_out), 1);
    rst = 1'b1;
    #1;
    check("rst_lock_lock", int'(locked_out), 0);
    check("rst_lock_ready", int'(ser_ready), 1);
    check("rst_lock_fc", int'(fail_count), 0);
    @(negedge clk);
    rst = 1'b0;
    run_code(4'b1011, 0, 1'b1, 0, 1'b0, "rst_lock_pass");

`ifdef SERIAL_CODE_LOCK_PROG_EN
    // Armed by the pass above: program a new code
    prog_req  = 1'b1;
    prog_code = 4'b0110;
    @(posedge clk);
    #1 prog_req = 1'b0;
    run_code(4'b1011, 0, 1'b0, 1, 1'b0, "prog_old");
    run_code(4'b0110, 0, 1'b1, 0, 1'b0, "prog_new");
    // Disarm with a failing attempt, then a program request must be ignored
    run_code(4'b1011, 0, 1'b0, 1, 1'b0, "prog_disarm");
    @(negedge clk);
    prog_req  = 1'b1;
    prog_code = 4'b1011;
    @(posedge clk);
    #1 prog_req = 1'b0;
    run_code(4'b0110, 0, 1'b1, 0, 1'b0, "prog_ignored");
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
